// File: rtl/wimax_burst_ctrl.sv
// Burst sequencer ahead of the WiMAX randomizer: waits for PLL lock, reseeds the PRBS
// per 96-bit FEC block, gates the serial source through a valid/ready handshake, and spaces blocks with idle gaps.
module wimax_burst_ctrl #(
   parameter int BLOCK_BITS = 96,
   parameter int BLK_W      = 8,
   parameter int GAP_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             locked,
   input  logic             start,
   input  logic [BLK_W-1:0] num_blocks,
   input  logic             src_data,
   input  logic             src_valid,
   output logic             src_ready,
   output logic             prbs_load,
   output logic             prbs_en,
   output logic             prbs_valid_in,
   output logic             prbs_data_in,
   input  logic             prbs_ready,
   output logic             busy,
   output logic             done,
   output logic [BLK_W-1:0] blk_idx,
   output logic [6:0]       bit_idx,
   output logic             err_lock
);

   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [6:0] BIT_LAST = 7'(BLOCK_BITS - 1);

   typedef enum logic [2:0] {IDLE, WAIT_LOCK, LOAD, STREAM, GAP, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [BLK_W-1:0] blk_count;
   logic [GAP_W-1:0] gap_cnt;
   logic             zero_done;
   logic             in_stream;
   logic             transfer;
   logic             last_bit;
   logic             last_blk;

   assign in_stream = (state == STREAM);
   assign transfer  = in_stream & src_valid & prbs_ready;
   assign last_bit  = transfer & (bit_idx == BIT_LAST);
   assign last_blk  = (blk_idx == blk_count - BLK_W'(1));

   // The handshake is a straight passthrough, but only while streaming a block.
   assign src_ready     = in_stream & prbs_ready;
   assign prbs_valid_in = in_stream & src_valid;
   assign prbs_data_in  = in_stream & src_data;

   // A zero-length burst finishes from IDLE via its own registered flag so busy never rises.
   assign prbs_load = (state == LOAD);
   assign prbs_en   = in_stream;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE) | zero_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (start && num_blocks != '0) state_next = WAIT_LOCK;
         WAIT_LOCK: if (locked) state_next = LOAD;
         LOAD:      state_next = locked ? STREAM : IDLE;
         STREAM: begin
            if (!locked)       state_next = IDLE;
            else if (last_bit) state_next = last_blk ? DONE : GAP;
         end
         GAP: begin
            if (!locked)                  state_next = IDLE;
            else if (gap_cnt == GAP_LAST) state_next = LOAD;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Counters and sticky error; a transfer in the lock-loss cycle is still counted.
   always_ff @(posedge clk) begin
      if (reset) begin
         blk_count <= '0;
         blk_idx   <= '0;
         bit_idx   <= '0;
         gap_cnt   <= '0;
         err_lock  <= 1'b0;
         zero_done <= 1'b0;
      end else begin
         zero_done <= (state == IDLE) && start && (num_blocks == '0);
         case (state)
            IDLE: begin
               if (start) begin
                  err_lock <= 1'b0;
                  if (num_blocks != '0) begin
                     blk_count <= num_blocks;
                     blk_idx   <= '0;
                     bit_idx   <= '0;
                  end
               end
            end
            LOAD: begin
               bit_idx <= '0;
               if (!locked) err_lock <= 1'b1;
            end
            STREAM: begin
               if (transfer) bit_idx <= bit_idx + 7'd1;
               if (!locked) begin
                  err_lock <= 1'b1;
               end else if (last_bit && !last_blk) begin
                  blk_idx <= blk_idx + BLK_W'(1);
                  gap_cnt <= '0;
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt + GAP_W'(1);
               if (!locked) err_lock <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wimax_burst_ctrl.sv
// Self-checking bench for wimax_burst_ctrl: random payloads and handshakes, scored against
// block/timing rules (96 bits per block, load/gap/done latencies, in-order payload).
module tb_wimax_burst_ctrl;

   localparam int BITS = 96;
   localparam int GAP  = 4;

   logic       clk = 1'b0;
   logic       reset, locked, start, src_data, src_valid, prbs_ready;
   logic [7:0] num_blocks;
   logic       src_ready, prbs_load, prbs_en, prbs_valid_in, prbs_data_in, busy, done, err_lock;
   logic [7:0] blk_idx;
   logic [6:0] bit_idx;

   wimax_burst_ctrl #(.BLOCK_BITS(BITS), .BLK_W(8), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .reset(reset), .locked(locked), .start(start), .num_blocks(num_blocks),
      .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
      .prbs_load(prbs_load), .prbs_en(prbs_en), .prbs_valid_in(prbs_valid_in),
      .prbs_data_in(prbs_data_in), .prbs_ready(prbs_ready), .busy(busy), .done(done),
      .blk_idx(blk_idx), .bit_idx(bit_idx), .err_lock(err_lock)
   );

   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;

   // scenario knobs
   int nblk, mode, lock_delay, drop_at, restart_at, reset_at;

   // scoreboard state
   int cyc = 0;
   int start_cyc, drop_cyc, reset_cyc, fall_cyc;
   int n_xfer, en_cnt, busy_seen, tx_ptr;
   bit last_busy;
   int load_cyc[$];
   int load_blk[$];
   int seg_cnt[$];
   int seg_last[$];
   int done_cyc[$];
   bit rx_q[$];
   bit tx_bits[$];

   task automatic checkOutput(input string tag, input int observed, input int expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // One clock cycle: present src_data, sample at the falling edge, then cross the rising edge.
   task automatic applyStimulus();
      src_data = (tx_ptr < tx_bits.size()) ? tx_bits[tx_ptr] : 1'b0;
      #4;
      checkOutput("ready_gate", int'(src_ready && !prbs_ready), 0);
      checkOutput("valid_gate", int'(prbs_valid_in && !src_valid), 0);
      checkOutput("load_en_excl", int'(prbs_load && prbs_en), 0);
      if (prbs_load) begin
         load_cyc.push_back(cyc);
         load_blk.push_back(int'(blk_idx));
         seg_cnt.push_back(0);
         seg_last.push_back(cyc);
      end
      if (prbs_en) en_cnt++;
      if (done) done_cyc.push_back(cyc);
      if (busy) busy_seen++;
      if (!busy && last_busy) fall_cyc = cyc;
      last_busy = busy;
      if (src_ready && src_valid) begin
         checkOutput("passthru", int'(prbs_data_in), int'(src_data));
         rx_q.push_back(prbs_data_in);
         n_xfer++;
         tx_ptr++;
         if (seg_cnt.size() > 0) begin
            seg_cnt[seg_cnt.size()-1] += 1;
            seg_last[seg_last.size()-1] = cyc;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic configure(input int nb, input int md, input int ld, input int da, input int ra, input int rs);
      nblk = nb; mode = md; lock_delay = ld; drop_at = da; restart_at = ra; reset_at = rs;
   endtask

   task automatic runBurst();
      int budget;
      int off_cnt;
      bit dropped, restarted, reset_done;
      load_cyc.delete(); load_blk.delete(); seg_cnt.delete(); seg_last.delete();
      done_cyc.delete(); rx_q.delete(); tx_bits.delete();
      for (int i = 0; i < nblk * BITS + 8; i++) tx_bits.push_back(1'($urandom));
      n_xfer = 0; en_cnt = 0; busy_seen = 0; tx_ptr = 0; last_busy = 1'b0;
      drop_cyc = -1; reset_cyc = -1; fall_cyc = -1;
      budget = 0; off_cnt = 0; dropped = 0; restarted = 0; reset_done = 0;
      start = 1'b1; num_blocks = 8'(nblk); src_valid = 1'b1; prbs_ready = 1'b1; locked = 1'b1;
      start_cyc = cyc;
      applyStimulus();
      start = 1'b0;
      num_blocks = 8'($urandom);
      checkOutput("err_clear_on_start", int'(err_lock), 0);
      while (!(busy_seen > 0 && !last_busy) && budget < 400 * nblk + 200) begin
         locked = !((cyc - start_cyc) >= 1 && (cyc - start_cyc) <= lock_delay);
         if (drop_at >= 0 && n_xfer == drop_at && !dropped) begin
            locked = 1'b0; dropped = 1; drop_cyc = cyc;
         end
         start = 1'b0;
         if (restart_at >= 0 && n_xfer == restart_at && !restarted) begin
            start = 1'b1; num_blocks = 8'd5; restarted = 1;
         end
         reset = 1'b0;
         if (reset_at >= 0 && n_xfer == reset_at && !reset_done) begin
            reset = 1'b1; reset_done = 1; reset_cyc = cyc;
         end
         case (mode)
            1: begin
               prbs_ready = cyc[0];
               src_valid = 1'b1;
               if (n_xfer >= 48 && off_cnt < 10) begin
                  src_valid = 1'b0; off_cnt++;
               end
            end
            2: begin
               prbs_ready = ($urandom_range(0, 3) != 0);
               src_valid = ($urandom_range(0, 3) != 0);
            end
            default: begin
               prbs_ready = 1'b1; src_valid = 1'b1;
            end
         endcase
         applyStimulus();
         budget++;
      end
      start = 1'b0; reset = 1'b0; locked = 1'b1;
      checkOutput("burst_end", int'(busy_seen > 0 && !last_busy), 1);
   endtask

   task automatic checkNormal();
      int bad;
      checkOutput("load_count", load_cyc.size(), nblk);
      if (load_cyc.size() > 0) checkOutput("start_to_load", load_cyc[0] - start_cyc, lock_delay + 2);
      for (int k = 0; k < load_cyc.size(); k++) begin
         checkOutput("seg_bits", seg_cnt[k], BITS);
         checkOutput("load_blk_idx", load_blk[k], k);
         if (k > 0) checkOutput("gap_latency", load_cyc[k] - seg_last[k-1], GAP + 1);
      end
      checkOutput("done_count", done_cyc.size(), 1);
      if (done_cyc.size() > 0 && seg_last.size() > 0)
         checkOutput("last_to_done", done_cyc[0] - seg_last[seg_last.size()-1], 1);
      checkOutput("total_xfer", n_xfer, nblk * BITS);
      bad = 0;
      for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== tx_bits[i]) bad++;
      checkOutput("payload_order", bad, 0);
      checkOutput("final_bit_idx", int'(bit_idx), BITS);
      checkOutput("final_blk_idx", int'(blk_idx), nblk - 1);
      checkOutput("err_lock_clean", int'(err_lock), 0);
   endtask

   initial begin
      reset = 1'b1; locked = 1'b1; start = 1'b0; num_blocks = '0;
      src_data = 1'b0; src_valid = 1'b1; prbs_ready = 1'b1;
      configure(0, 0, 0, -1, -1, -1);
      tx_ptr = 0;
      applyStimulus(); applyStimulus();
      checkOutput("reset_outputs",
                  int'({src_ready, prbs_load, prbs_en, prbs_valid_in, prbs_data_in, busy, done, err_lock}), 0);
      checkOutput("reset_idx", int'({blk_idx, bit_idx}), 0);
      reset = 1'b0;
      applyStimulus();

      $display("[TB] single block, continuous source");
      configure(1, 0, 0, -1, -1, -1);
      runBurst();
      checkNormal();
      if (done_cyc.size() > 0) checkOutput("start_to_done", done_cyc[0] - start_cyc, 99);

      $display("[TB] three blocks, continuous source");
      configure(3, 0, 0, -1, -1, -1);
      runBurst();
      checkNormal();
      checkOutput("en_cycles", en_cnt, 3 * BITS);

      $display("[TB] backpressure");
      configure(1, 1, 0, -1, -1, -1);
      runBurst();
      checkNormal();

      $display("[TB] lock loss at bit 50");
      configure(2, 0, 0, 50, -1, -1);
      runBurst();
      checkOutput("drop_err_lock", int'(err_lock), 1);
      checkOutput("drop_idle_next", fall_cyc - drop_cyc, 1);
      checkOutput("drop_no_done", done_cyc.size(), 0);
      checkOutput("drop_bits", int'(bit_idx), 51);
      checkOutput("drop_xfer", n_xfer, 51);

      $display("[TB] restart after lock loss");
      configure(1, 0, 0, -1, -1, -1);
      runBurst();
      checkNormal();

      $display("[TB] start while unlocked");
      configure(1, 0, 20, -1, -1, -1);
      runBurst();
      checkNormal();

      $display("[TB] zero-block burst");
      busy_seen = 0;
      done_cyc.delete();
      start = 1'b1; num_blocks = 8'd0;
      applyStimulus();
      start = 1'b0;
      checkOutput("zero_done_pulse", int'(done), 1);
      checkOutput("zero_busy", int'(busy), 0);
      applyStimulus();
      checkOutput("zero_done_clear", int'(done), 0);
      checkOutput("zero_busy_never", busy_seen, 0);
      checkOutput("zero_done_count", done_cyc.size(), 1);

      $display("[TB] start during stream ignored");
      configure(2, 0, 0, -1, 20, -1);
      runBurst();
      checkNormal();

      $display("[TB] reset at bit 30");
      configure(2, 0, 0, -1, -1, 30);
      runBurst();
      checkOutput("midreset_next", fall_cyc - reset_cyc, 1);
      checkOutput("midreset_outputs",
                  int'({src_ready, prbs_load, prbs_en, prbs_valid_in, prbs_data_in, busy, done, err_lock}), 0);
      checkOutput("midreset_idx", int'({blk_idx, bit_idx}), 0);

      $display("[TB] fresh burst after reset");
      configure(1, 0, 0, -1, -1, -1);
      runBurst();
      checkNormal();

      $display("[TB] random handshake, two blocks");
      configure(2, 2, 0, -1, -1, -1);
      runBurst();
      checkNormal();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
